// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/burst encodings, manager FSM states and beat-count helper
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_t;
  function automatic logic [4:0] beats_of(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   return 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd1;
    endcase
  endfunction
endpackage

// File: rtl/ahb_mgr_addr_gen.sv
// ahb_mgr_addr_gen: combinational next-beat address for INCR/WRAP bursts
//   i_addr/i_size/i_burst: current beat address, hsize, hburst; o_next: next beat address
module ahb_mgr_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [2:0]        i_burst,
  output logic [ADDR_W-1:0] o_next
);
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_mask;
  logic              w_wrap;
  assign w_inc  = i_addr + (ADDR_W'(1) << i_size);
  // wrap window spans beats*2^size bytes, aligned to its own size
  assign w_mask = (ADDR_W'(beats_of(i_burst)) << i_size) - ADDR_W'(1);
  assign w_wrap = !i_burst[0] && (i_burst != HBURST_SINGLE);
  assign o_next = w_wrap ? ((i_addr & ~w_mask) | (w_inc & w_mask)) : w_inc;
endmodule

// File: rtl/ahb_mgr.sv
// ahb_mgr: single-outstanding AHB manager turning one command into a SINGLE/INCRn/WRAPn burst
//   command: req_valid/req_ready/req_write/req_addr/req_size/req_burst
//   write data: wr_data in, wr_pop pulse per completed write beat
//   read data: rd_data/rd_valid per completed OKAY read beat
//   status: done pulse at command end, err with done (ERROR response or misaligned request)
//   AHB: hsel/haddr/htrans/hwrite/hsize/hburst/hwdata out, hrdata/hready/hresp in
//   AHB_MGR_ERR_CANCEL_EN: cancel remaining beats on the first ERROR response cycle
module ahb_mgr
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [2:0]        req_burst,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [1:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_haddr, w_addr_nxt;
  logic [1:0]        r_hsize;
  logic [2:0]        r_hburst;
  logic              r_hwrite, r_err_flag, r_done, r_err, r_rd_valid;
  logic [3:0]        r_left;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_accept, w_misalign, w_dphase, w_aphase, w_cancel;
  ahb_mgr_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_addr (r_haddr),
    .i_size (r_hsize),
    .i_burst(r_hburst),
    .o_next (w_addr_nxt)
  );
  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_misalign = |(req_addr & ((ADDR_W'(1) << req_size) - ADDR_W'(1)));
  assign w_aphase   = (r_state == S_ADDR) || (r_state == S_BURST);
  assign w_dphase   = (r_state == S_BURST) || (r_state == S_LAST);
`ifdef AHB_MGR_ERR_CANCEL_EN
  // first ERROR cycle still has hready=0, so the pending SEQ address was never taken
  assign w_cancel = (r_state == S_BURST) && hresp && !hready;
`else
  assign w_cancel = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !w_misalign) w_next = S_ADDR;
      S_ADDR:  if (hready) w_next = (r_left == 4'd0) ? S_LAST : S_BURST;
      S_BURST: if (w_cancel || (hready && r_left == 4'd0)) w_next = S_LAST;
      S_LAST:  if (hready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_haddr    <= '0;
      r_hsize    <= '0;
      r_hburst   <= '0;
      r_hwrite   <= 1'b0;
      r_left     <= '0;
      r_err_flag <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      if (w_accept && !w_misalign) begin
        r_haddr    <= req_addr;
        r_hsize    <= req_size;
        r_hburst   <= (req_burst == HBURST_INCR) ? HBURST_SINGLE : req_burst;
        r_hwrite   <= req_write;
        r_left     <= 4'(beats_of(req_burst) - 5'd1);
        r_err_flag <= 1'b0;
      end
      if (w_accept && w_misalign) begin
        r_done <= 1'b1;
        r_err  <= 1'b1;
      end
      if (w_aphase && hready && r_left != 4'd0) begin
        r_haddr <= w_addr_nxt;
        r_left  <= r_left - 4'd1;
      end
      if (w_dphase && hresp) r_err_flag <= 1'b1;
      if (w_dphase && hready && !hresp && !r_hwrite) begin
        r_rd_data  <= hrdata;
        r_rd_valid <= 1'b1;
      end
      if (r_state == S_LAST && hready) begin
        r_done <= 1'b1;
        r_err  <= r_err_flag | hresp;
      end
    end
  end
  assign req_ready = (r_state == S_IDLE);
  assign htrans    = (r_state == S_ADDR) ? HTRANS_NONSEQ : (r_state == S_BURST) ? HTRANS_SEQ : HTRANS_IDLE;
  assign hsel      = (r_state != S_IDLE);
  assign haddr     = r_haddr;
  assign hwrite    = r_hwrite;
  assign hsize     = r_hsize;
  assign hburst    = r_hburst;
  assign hwdata    = (w_dphase && r_hwrite) ? wr_data : '0;
  assign wr_pop    = w_dphase && r_hwrite && hready;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign err       = r_err;
endmodule

// File: tb/tb_ahb_mgr.sv
// tb_ahb_mgr: directed self-checking bench for ahb_mgr with a small AHB subordinate model
module tb_ahb_mgr;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [2:0]  req_burst = '0;
  logic [63:0] wr_data = '0, rd_data, hwdata, hrdata;
  logic        wr_pop, rd_valid, done, err, hsel, hwrite;
  logic [9:0]  haddr;
  logic [1:0]  htrans, hsize;
  logic [2:0]  hburst;
  logic        hready = 1'b1, hresp = 1'b0;

  int checks = 0, errors = 0;
  int wr_n = 0, done_n = 0, held_n = 0, hold_bad = 0;
  logic last_err = 1'b0;
  logic [1:0] post_htrans = 2'b00;
  logic [63:0] addr_q[$], rd_q[$], hw_q[$];
  logic [63:0] wbase = '0;
  logic samp_acc = 1'b0, samp_rdy = 1'b0, p_held = 1'b0;
  logic [9:0] samp_addr = '0, p_addr = '0;
  logic [1:0] p_trans = '0;
  logic dp_valid;
  int dp_beat;
  logic [9:0] dp_addr;

  ahb_mgr #(.ADDR_W(10), .DATA_W(64)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_burst(req_burst),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  // subordinate returns a tag of the data-phase address as read data
  assign hrdata = {32'hC0DE_0000, 22'd0, dp_addr};

  always @(negedge clk) begin
    samp_acc  = htrans[1] && hready;
    samp_rdy  = hready;
    samp_addr = haddr;
    if (samp_acc) addr_q.push_back(64'(haddr));
    if (wr_pop) begin
      wr_n++;
      hw_q.push_back(hwdata);
    end
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) begin
      done_n++;
      last_err = err;
    end
    if (htrans[1] && !hready) held_n++;
    if (p_held && (haddr !== p_addr || htrans !== p_trans)) hold_bad++;
    p_held  = htrans[1] && !hready;
    p_addr  = haddr;
    p_trans = htrans;
    if (hresp && hready) post_htrans = htrans;
  end

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_valid <= 1'b0;
      dp_beat  <= 0;
      dp_addr  <= '0;
    end else if (samp_acc) begin
      dp_valid <= 1'b1;
      dp_beat  <= addr_q.size();
      dp_addr  <= samp_addr;
    end else if (samp_rdy) begin
      dp_valid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [63:0] q[$],
                      input logic [63:0] e0, input logic [63:0] e1,
                      input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_n"}, 64'(q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_%0d", tag, i), (i < q.size()) ? q[i] : 64'hx, e[i]);
  endtask

  task automatic issue(input logic wr, input logic [9:0] a, input logic [1:0] sz, input logic [2:0] b);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_burst = b;
    hready = 1'b1; hresp = 1'b0; wr_data = wbase;
    addr_q.delete(); rd_q.delete(); hw_q.delete();
    held_n = 0; hold_bad = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run(input logic waits, input int err_beat);
    int d0 = done_n;
    int w0 = wr_n;
    int est = 0;
    logic tog = 1'b0;
    logic fin = 1'b0;
    for (int c = 0; c < 80 && !fin; c++) begin
      if (err_beat != 0 && est == 0 && dp_valid && dp_beat == err_beat) begin
        hready = 1'b0; hresp = 1'b1; est = 1;
      end else if (est == 1) begin
        hready = 1'b1; hresp = 1'b1; est = 2;
      end else begin
        hready = waits ? tog : 1'b1; hresp = 1'b0;
      end
      tog = !tog;
      wr_data = wbase + 64'(wr_n - w0);
      @(negedge clk); #1;
      fin = (done_n != d0);
      @(posedge clk); #1;
    end
    hready = 1'b1; hresp = 1'b0;
    chk("done_seen", 64'(fin), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_htrans", 64'(htrans), 64'd0);
    chk("rst_hsel", 64'(hsel), 64'd0);
    chk("rst_haddr", 64'(haddr), 64'd0);
    chk("rst_ctrl", {59'd0, hwrite, hsize, hburst} , 64'd0);
    chk("rst_pulses", {60'd0, wr_pop, rd_valid, done, err}, 64'd0);
    chk("rst_data", hwdata | rd_data, 64'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(req_ready), 64'd1);

    // single write
    wbase = 64'h0002_0002_0002_0002;
    issue(1'b1, 10'h008, 2'd3, 3'b000);
    hready = 1'b1;
    @(negedge clk); #1;
    chk("sw_htrans", 64'(htrans), 64'd2);
    chk("sw_haddr", 64'(haddr), 64'h008);
    chk("sw_ctrl", {59'd0, hsel, hwrite, hsize}, 64'b1_1_11);
    chk("sw_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("sw_dphase_htrans", 64'(htrans), 64'd0);
    chk("sw_hwdata", hwdata, 64'h0002_0002_0002_0002);
    chk("sw_wr_pop", 64'(wr_pop), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("sw_done_err", {62'd0, done, err}, 64'b10);
    chk("sw_ready_back", 64'(req_ready), 64'd1);

    // INCR4 read with one wait state per phase
    issue(1'b0, 10'h000, 2'd3, 3'b011);
    run(1'b1, 0);
    chk4("i4_addr", addr_q, 64'h000, 64'h008, 64'h010, 64'h018);
    chk4("i4_rd", rd_q, 64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0008,
         64'hC0DE_0000_0000_0010, 64'hC0DE_0000_0000_0018);
    chk("i4_held", 64'(held_n), 64'd4);
    chk("i4_hold_bad", 64'(hold_bad), 64'd0);
    chk("i4_err", 64'(last_err), 64'd0);

    // WRAP4 write across the 32-byte boundary
    wbase = 64'h1111_2222_3333_0000;
    issue(1'b1, 10'h018, 2'd3, 3'b010);
    run(1'b0, 0);
    chk4("w4_addr", addr_q, 64'h018, 64'h000, 64'h008, 64'h010);
    chk4("w4_hwdata", hw_q, 64'h1111_2222_3333_0000, 64'h1111_2222_3333_0001,
         64'h1111_2222_3333_0002, 64'h1111_2222_3333_0003);
    chk("w4_err", 64'(last_err), 64'd0);

    // INCR4 wraps modulo the address space
    issue(1'b0, 10'h3F0, 2'd3, 3'b011);
    run(1'b0, 0);
    chk4("i4wrap_addr", addr_q, 64'h3F0, 64'h3F8, 64'h000, 64'h008);

    // ERROR response on beat 2 of INCR8 read
    issue(1'b0, 10'h080, 2'd3, 3'b101);
    run(1'b0, 2);
    chk("e8_err", 64'(last_err), 64'd1);
`ifdef AHB_MGR_ERR_CANCEL_EN
    chk("e8_beats", 64'(addr_q.size()), 64'd2);
    chk("e8_rd_n", 64'(rd_q.size()), 64'd1);
    chk("e8_htrans_after", 64'(post_htrans), 64'd0);
`else
    chk("e8_beats", 64'(addr_q.size()), 64'd8);
    chk("e8_rd_n", 64'(rd_q.size()), 64'd7);
    chk("e8_htrans_after", 64'(post_htrans), 64'd3);
`endif

    // misaligned request
    issue(1'b1, 10'h022, 2'd3, 3'b000);
    @(negedge clk); #1;
    chk("mis_done_err", {62'd0, done, err}, 64'b11);
    chk("mis_htrans", 64'(htrans), 64'd0);
    chk("mis_hsel", 64'(hsel), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mis_no_bus", 64'(addr_q.size()), 64'd0);

    // reset in the middle of INCR16
    wbase = 64'h5;
    issue(1'b1, 10'h100, 2'd2, 3'b111);
    hready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("r16_busy", 64'(htrans), 64'd3);
    n_rst = 1'b0;
    #1;
    chk("r16_htrans", 64'(htrans), 64'd0);
    chk("r16_hsel", 64'(hsel), 64'd0);
    chk("r16_haddr", 64'(haddr), 64'd0);
    chk("r16_ctrl", {59'd0, hwrite, hsize, hburst}, 64'd0);
    chk("r16_data", hwdata | rd_data, 64'd0);
    chk("r16_pulses", {60'd0, wr_pop, rd_valid, done, err}, 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("r16_ready", 64'(req_ready), 64'd1);
    issue(1'b0, 10'h040, 2'd2, 3'b000);
    run(1'b0, 0);
    chk("post_rst_rd_n", 64'(rd_q.size()), 64'd1);
    chk("post_rst_rd", (rd_q.size() > 0) ? rd_q[0] : 64'hx, 64'hC0DE_0000_0000_0040);
    chk("post_rst_err", 64'(last_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_mgr.md
AHB_MGR -- requirements
Module: ahb_mgr

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the AHB address width.
REQ-002 Parameter DATA_W, default 64, SHALL set the hwdata/hrdata width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 n_rst  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  command request.
REQ-007 req_ready  out  1  command accepted when req_valid && req_ready.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  start byte address.
REQ-010 req_size  in  2  hsize of every beat.
REQ-011 req_burst  in  3  SINGLE/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16; INCR (001) treated as SINGLE.
REQ-012 wr_data  in  DATA_W  current write-beat data.
REQ-013 wr_pop  out  1  pulse: current write beat completed, present next beat.
REQ-014 rd_data  out  DATA_W  captured read beat; rd_valid  out  1  pulse, one per completed read beat.
REQ-015 done  out  1  one-cycle pulse at command end; err  out  1  valid with done, 1 = an ERROR response was seen or the request was misaligned.
REQ-016 AHB outputs: hsel 1, haddr ADDR_W, htrans 2, hwrite 1, hsize 2, hburst 3, hwdata DATA_W; AHB inputs: hrdata DATA_W, hready 1, hresp 1.

Function
REQ-017 req_ready SHALL be 1 only in IDLE; one command is in flight at a time.
REQ-018 A request with req_addr not aligned to 2^req_size SHALL produce done=err=1 in the next cycle, with no bus activity.
REQ-019 States: IDLE -> ADDR, which drives NONSEQ. ADDR -> BURST when hready=1 and beats remain; ADDR -> LAST when hready=1 and no beats remain. BURST drives SEQ plus the previous beat's data phase. BURST -> LAST after the final address is accepted. LAST drives htrans=IDLE and the final data phase. LAST -> IDLE on hready=1, pulsing done.
REQ-020 The first address phase SHALL appear on the cycle after acceptance, giving a latency of 1.
REQ-021 Address and control SHALL be held unchanged while hready=0; the next address is issued only after an hready=1 edge.
REQ-022 Address step SHALL be 2^req_size. INCRn SHALL wrap modulo 2^ADDR_W. WRAPn SHALL wrap at an n*2^req_size byte boundary.
REQ-023 Beat count SHALL be 1/4/8/16, from req_burst.
REQ-024 Writes: hwdata SHALL equal wr_data during each data phase; wr_pop SHALL pulse on each data-phase cycle that has hready=1.
REQ-025 Reads: rd_data SHALL capture hrdata, and rd_valid SHALL pulse, on each data-phase cycle that has hready=1 and hresp=0.
REQ-026 hsel SHALL be 1 exactly when htrans is NONSEQ or SEQ, or a data phase is pending.
REQ-027 An ERROR response (hresp=1, hready=0, then hresp=1, hready=1) SHALL set a sticky error flag for the command, reported on err with done.

Reset
REQ-028 Assertion of n_rst SHALL, at any time including mid-burst, force state IDLE.
REQ-029 Reset values: htrans=00, hsel=0, hwrite=0, haddr=0, hsize=0, hburst=0, hwdata=0, rd_data=0, all pulses 0, req_ready=1 one cycle after release.

Configuration
REQ-030 With AHB_MGR_ERR_CANCEL_EN defined, the first ERROR cycle (hready=0) SHALL drive htrans=IDLE on the next cycle, cancel the remaining beats, and end with done=err=1.
REQ-031 Without AHB_MGR_ERR_CANCEL_EN, the burst SHALL run all beats and err SHALL be reported at done.

Structure
REQ-032 Package ahb_pkg SHALL hold the HTRANS_* and HBURST_* constants, the state enum, and a beats_of(hburst) function.
REQ-033 Next-address computation SHALL live in sub-module ahb_mgr_addr_gen, which is combinational: addr, size, burst -> next addr.

Verification
REQ-034 Single write: req addr 0x008, size 3, data 0x0002000200020002, hready=1 -> NONSEQ at 0x008; hwdata correct one cycle later; wr_pop=1; done=1, err=0 on the next cycle.
REQ-035 INCR4 read from 0x000 with 1 wait state per beat -> haddr 0x000, 0x008, 0x010, 0x018; 4 rd_valid pulses; each address held during its wait cycle.
REQ-036 WRAP4 write from 0x018, size 3 -> haddr 0x018, 0x000, 0x008, 0x010; 4 wr_pop pulses.
REQ-037 ERROR on beat 2 of INCR8: with the macro, htrans=IDLE after the first ERROR cycle and done=err=1 with only 2 beats issued; without the macro, 8 beats are issued and err=1.
REQ-038 Misaligned request (addr 0x022, size 3) -> done=err=1 next cycle and htrans stays IDLE; n_rst pulsed mid-INCR16 -> all outputs at reset values, and a new command is accepted afterward.
